// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: program sequencer on the responder side of the start/done run
// handshake. Owns the instruction ROM address, qualifies datapath commits, and
// ends a run on HALT or when the RUN-cycle watchdog expires.
module cpu_run_ctrl #(
  parameter int PC_W       = 7,
  parameter int INSTR_W    = 9,
  parameter int MAX_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               done,
  output logic               timeout,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               zero_flag,
  output logic               exec_en,
  output logic [9:0]         cycle_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state;
  logic [2:0]           opcode;
  logic [INSTR_W-4:0]   operand;
  logic [PC_W-1:0]      target;
  logic                 is_halt;
  logic                 is_jmp;
  logic                 is_brz;
  logic [PC_W-1:0]      pc_next;
  logic [9:0]           cnt_next;
  logic                 wd_hit;

  // Instruction decode; branch/jump targets are the operand zero-extended
  always_comb begin
    opcode  = instr[INSTR_W-1 -: 3];
    operand = instr[INSTR_W-4:0];
    target  = PC_W'(operand);
    is_halt = (opcode == 3'b111) && (operand == '0);
    is_jmp  = (opcode == 3'b111) && (operand != '0);
    is_brz  = (opcode == 3'b110);
  end

  // Next PC for an executing instruction (sequential flow wraps naturally)
  always_comb begin
    pc_next = pc + 1'b1;
    if (is_jmp)
      pc_next = target;
    else if (is_brz && zero_flag)
      pc_next = target;
  end

  // Saturating cycle counter increment and watchdog expiry on that value
  always_comb begin
    cnt_next = (cycle_count == 10'd1023) ? cycle_count : cycle_count + 10'd1;
    wd_hit   = (MAX_CYCLES != 0) && ({22'd0, cnt_next} == 32'(MAX_CYCLES)) && !is_halt;
  end

  // Commit qualifier: only in RUN, never for HALT, and suppressed during reset
  always_comb begin
    exec_en = reset && (state == S_RUN) && !is_halt;
  end

  // Run-control FSM with PC, counter and status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_RUN;
            pc          <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
          end
        end
        S_RUN: begin
          cycle_count <= cnt_next;
          if (is_halt) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            // The expiring instruction still executes, so its PC step lands
            pc <= pc_next;
            if (wd_hit) begin
              state   <= S_DONE;
              done    <= 1'b1;
              timeout <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
